// File: rtl/mesh_router_rr.sv
// mesh_router_rr: four-port (N/E/S/W) mesh router with row-first routing, round-robin
// input arbitration that skips blocked inputs, broadcast, self-address drop counting.
//
// state | meaning
// IDLE  | scan inputs from rr, latch the first one whose target(s) have room
// XFER  | pop granted input, push latched packet into target FIFO(s) or count a drop
module mesh_router_rr #(
  parameter int         PCKG_SZ    = 40,
  parameter int         FIFO_DEPTH = 4,
  parameter int         ID_R       = 1,
  parameter int         ID_C       = 1,
  parameter int         ROWS       = 4,
  parameter int         COLUMNS    = 4,
  parameter logic [7:0] BDCST      = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PCKG_SZ-1:0] in_data [4],
  input  logic [3:0]         in_pndng,
  output logic [3:0]         in_pop,
  output logic [PCKG_SZ-1:0] out_data [4],
  output logic [3:0]         out_pndng,
  input  logic [3:0]         out_pop,
  output logic [7:0]         drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  if (PCKG_SZ < 16 || FIFO_DEPTH < 2 || ID_R < 1 || ID_R > ROWS ||
      ID_C < 1 || ID_C > COLUMNS) begin : g_bad_cfg
    $error("mesh_router_rr: illegal parameter set");
  end

  // Target mask per packet; an all-zero mask means the packet is addressed here and dropped.
  function automatic logic [3:0] route(input logic [PCKG_SZ-1:0] d, input logic [1:0] src);
    logic [3:0] dr;
    logic [3:0] dc;
    dr = d[PCKG_SZ-1 -: 4];
    dc = d[PCKG_SZ-5 -: 4];
    if (d[PCKG_SZ-1 -: 8] == BDCST) route = ~(4'b0001 << src);
    else if (dr < 4'(ID_R))         route = 4'b0001;
    else if (dr > 4'(ID_R))         route = 4'b0100;
    else if (dc > 4'(ID_C))         route = 4'b0010;
    else if (dc < 4'(ID_C))         route = 4'b1000;
    else                            route = 4'b0000;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [0:0]         state;
  logic [1:0]         rr;
  logic [1:0]         g;
  logic [PCKG_SZ-1:0] dat;
  logic [3:0]         mask;

  logic [PCKG_SZ-1:0] mem    [4][FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr [4];
  logic [PW-1:0]      rd_ptr [4];
  logic [CW-1:0]      cnt    [4];

  logic [3:0] tgt [4];
  logic [3:0] full;
  logic [3:0] qual;
  logic [3:0] push;
  logic [3:0] pop_ok;
  logic       hit;
  logic [1:0] pick;
  logic [1:0] idx;

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      full[p] = (cnt[p] == CW'(FIFO_DEPTH));
    end
    for (int p = 0; p < 4; p++) begin
      tgt[p]  = route(in_data[p], 2'(p));
      qual[p] = in_pndng[p] && ((tgt[p] & full) == 4'b0000);
    end
  end

  always_comb begin
    hit  = 1'b0;
    pick = rr;
    idx  = rr;
    for (int i = 0; i < 4; i++) begin
      idx = rr + 2'(i);
      if (!hit && qual[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= '0;
      g        <= '0;
      dat      <= '0;
      mask     <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            g     <= pick;
            dat   <= in_data[pick];
            mask  <= tgt[pick];
            state <= XFER;
          end
        end
        XFER: begin
          rr    <= g + 2'd1;
          state <= IDLE;
          if (mask == 4'b0000 && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_pop comes only from registers, so a reset during XFER withdraws it at once.
  assign in_pop = (state == XFER) ? (4'b0001 << g) : 4'b0000;
  assign push   = (state == XFER) ? mask : 4'b0000;
  assign pop_ok = out_pop & out_pndng;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int q = 0; q < 4; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < 4; q++) begin
        if (push[q])   wr_ptr[q] <= next_ptr(wr_ptr[q]);
        if (pop_ok[q]) rd_ptr[q] <= next_ptr(rd_ptr[q]);
        case ({push[q], pop_ok[q]})
          2'b10:   cnt[q] <= cnt[q] + CW'(1);
          2'b01:   cnt[q] <= cnt[q] - CW'(1);
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

  // Storage is not reset; out_data is masked while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (push[q]) mem[q][wr_ptr[q]] <= dat;
    end
  end

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      out_pndng[q] = (cnt[q] != '0);
      out_data[q]  = (cnt[q] != '0) ? mem[q][rd_ptr[q]] : '0;
    end
  end

endmodule

// File: tb/tb_mesh_router_rr.sv
// Scoreboard bench for mesh_router_rr at grid point (2,2) of a 4x4 mesh: upstream FIFO
// models feed the inputs, a monitor checks every output pop against per-port expected queues.
module tb_mesh_router_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] in_data [4];
  logic [3:0]  in_pndng;
  logic [3:0]  in_pop;
  logic [39:0] out_data [4];
  logic [3:0]  out_pndng;
  logic [3:0]  out_pop;
  logic [7:0]  drop_cnt;

  logic [3:0]  drain_en  = 4'hF;
  logic [3:0]  force_pop = 4'h0;
  logic [39:0] up_q  [4][$];
  logic [39:0] exp_q [4][$];
  logic [39:0] mon_e;
  int          pop_cnt [4] = '{default: 0};
  int          n_tests = 0;
  int          n_fail  = 0;

  mesh_router_rr #(
    .PCKG_SZ(40), .FIFO_DEPTH(4), .ID_R(2), .ID_C(2), .ROWS(4), .COLUMNS(4), .BDCST(8'hFF)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_pndng(in_pndng), .in_pop(in_pop),
    .out_data(out_data), .out_pndng(out_pndng), .out_pop(out_pop),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  assign out_pop = (drain_en & out_pndng) | force_pop;

  // Upstream FIFO model: consume on in_pop, then present the new head.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (in_pop[p]) begin
        pop_cnt[p]++;
        if (up_q[p].size() != 0) void'(up_q[p].pop_front());
      end
    end
    for (int p = 0; p < 4; p++) begin
      in_pndng[p] = (up_q[p].size() != 0);
      in_data[p]  = (up_q[p].size() != 0) ? up_q[p][0] : 40'h0;
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (!rst && out_pop[p] && out_pndng[p]) begin
        n_tests++;
        if (exp_q[p].size() == 0) begin
          n_fail++;
          $display("FAIL out%0d_unexpected: got %h, expected no packet", p, out_data[p]);
        end else begin
          mon_e = exp_q[p].pop_front();
          if (out_data[p] !== mon_e) begin
            n_fail++;
            $display("FAIL out%0d_data: got %h, expected %h", p, out_data[p], mon_e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int p, input logic [7:0] hdr, input logic [31:0] pay,
                      input logic [3:0] m);
    logic [39:0] pk;
    pk = {hdr, pay};
    up_q[p].push_back(pk);
    for (int q = 0; q < 4; q++) if (m[q]) exp_q[q].push_back(pk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (up_q[0].size() == 0 && up_q[1].size() == 0 && up_q[2].size() == 0 &&
          up_q[3].size() == 0 && exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
          exp_q[2].size() == 0 && exp_q[3].size() == 0 && in_pop == 4'b0 &&
          out_pndng == 4'b0)
        done = 1'b1;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;

    repeat (2) tick();
    check("rst_in_pop", 64'(in_pop), 64'd0);
    check("rst_out_pndng", 64'(out_pndng), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int q = 0; q < 4; q++) check($sformatf("rst_out_data%0d", q), 64'(out_data[q]), 64'd0);
    rst = 1'b0;
    tick();

    // Unicast: 8'h12 from E goes north.
    send(1, 8'h12, 32'hA000_0001, 4'b0001);
    @(posedge clk); #1;
    check("uc_pop", 64'(in_pop), 64'b0010);
    @(posedge clk); #1;
    check("uc_pop_end", 64'(in_pop), 64'd0);
    check("uc_pndng", 64'(out_pndng), 64'b0001);
    check("uc_data", 64'(out_data[0]), 64'h12_A000_0001);
    wait_idle("uc_idle", 20);

    // Round-robin from rr=0, one grant every two cycles.
    do_reset();
    send(0, 8'h12, 32'hA100_0000, 4'b0001);
    send(1, 8'h32, 32'hA100_0001, 4'b0100);
    send(2, 8'h23, 32'hA100_0002, 4'b0010);
    send(3, 8'h21, 32'hA100_0003, 4'b1000);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("rr_c%0d", c), 64'(in_pop),
            (c % 2 == 1) ? (64'd1 << ((c - 1) / 2)) : 64'd0);
    end
    wait_idle("rr_idle", 40);

    // Backpressure: fill output E, then a blocked E packet must not stall S traffic.
    do_reset();
    drain_en = 4'b1101;
    for (int i = 0; i < 4; i++) send(0, 8'h23, 32'hB000_0000 + 32'(i), 4'b0010);
    repeat (12) tick();
    check("bp_fill_done", 64'(up_q[0].size()), 64'd0);
    check("bp_e_pndng", 64'(out_pndng[1]), 64'd1);
    base = pop_cnt[3];
    send(3, 8'h23, 32'hB000_0005, 4'b0010);
    send(0, 8'h32, 32'hB000_0006, 4'b0100);
    repeat (12) tick();
    check("bp_blocked_pops", 64'(pop_cnt[3] - base), 64'd0);
    check("bp_blocked_waiting", 64'(up_q[3].size()), 64'd1);
    check("bp_other_served", 64'(exp_q[2].size()), 64'd0);
    force_pop = 4'b0010;
    tick();
    force_pop = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < 2 && !found; k++) begin
      @(negedge clk);
      if (in_pop[3]) found = 1'b1;
    end
    check("bp_regrant", 64'(found), 64'd1);
    tick();
    drain_en = 4'hF;
    wait_idle("bp_idle", 40);

    // Broadcast from S lands on N, E, W on the same edge.
    do_reset();
    send(2, 8'hFF, 32'hC000_0001, 4'b1011);
    @(posedge clk); #1;
    check("bc_pop", 64'(in_pop), 64'b0100);
    @(posedge clk); #1;
    check("bc_pndng", 64'(out_pndng), 64'b1011);
    wait_idle("bc_idle", 20);
    drain_en = 4'b0111;
    for (int i = 0; i < 4; i++) send(0, 8'h21, 32'hC000_0010 + 32'(i), 4'b1000);
    repeat (12) tick();
    check("bc_w_full", 64'(up_q[0].size()), 64'd0);
    base = pop_cnt[2];
    send(2, 8'hFF, 32'hC000_0020, 4'b1011);
    repeat (10) tick();
    check("bc_blocked_pops", 64'(pop_cnt[2] - base), 64'd0);
    check("bc_blocked_pndng", 64'(out_pndng[0] | out_pndng[1]), 64'd0);
    drain_en = 4'hF;
    wait_idle("bc_late_idle", 40);
    check("bc_late_pops", 64'(pop_cnt[2] - base), 64'd1);

    // Self-addressed drop and counter saturation.
    do_reset();
    base = pop_cnt[0];
    send(0, 8'h22, 32'hD000_0000, 4'b0000);
    wait_idle("drop_idle", 20);
    check("drop_cnt1", 64'(drop_cnt), 64'd1);
    check("drop_no_push", 64'(out_pndng), 64'd0);
    for (int i = 1; i < 300; i++) send(0, 8'h22, 32'hD000_0000 + 32'(i), 4'b0000);
    wait_idle("drop_sat_idle", 1000);
    check("drop_pops", 64'(pop_cnt[0] - base), 64'd300);
    check("drop_sat", 64'(drop_cnt), 64'd255);

    // Reset during XFER: pop withdrawn, packet re-sent once after release.
    do_reset();
    base = pop_cnt[1];
    send(1, 8'h12, 32'hE000_0001, 4'b0001);
    @(posedge clk); #1;
    check("rm_pop", 64'(in_pop), 64'b0010);
    rst = 1'b1;
    #1;
    check("rm_pop_killed", 64'(in_pop), 64'd0);
    repeat (2) tick();
    check("rm_still_upstream", 64'(up_q[1].size()), 64'd1);
    rst = 1'b0;
    wait_idle("rm_idle", 20);
    repeat (5) tick();
    check("rm_pops_once", 64'(pop_cnt[1] - base), 64'd1);
    check("rm_empty", 64'(out_pndng), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_router_rr.md
# mesh_router_rr

Parametrised mesh router for the NoC emulation environment. It takes packets from 4 directional input channels (N, E, S, W) and routes each one row-first to a directional output FIFO. A round-robin arbiter selects the input, and an input whose target output is full is skipped, so one blocked input does not stall the others. The block also supports broadcast, drops self-addressed packets and counts the drops. One instance sits at each grid point of the mesh emulator.

## Interface
Parameters:
- PCKG_SZ, 40: packet width in bits; must be >= 16.
- FIFO_DEPTH, 4: entries per output FIFO; must be >= 2.
- ID_R, 1: row of this router; routers occupy rows 1..ROWS.
- ID_C, 1: column of this router; routers occupy columns 1..COLUMNS.
- ROWS, 4: mesh rows; terminals sit on rows 0 and ROWS+1.
- COLUMNS, 4: mesh columns; terminals sit on columns 0 and COLUMNS+1.
- BDCST, 8'hFF: header value that marks a broadcast packet.

Ports. Reset rst, asynchronous, active-high; clock clk. Port index order is 0=N, 1=E, 2=S, 3=W.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_data[4]  in  PCKG_SZ  head of each upstream FIFO.
- in_pndng[4]  in  1  upstream FIFO non-empty.
- in_pop[4]  out  1  one-cycle pop pulse to the upstream FIFO.
- out_data[4]  out  PCKG_SZ  head of each output FIFO (show-ahead).
- out_pndng[4]  out  1  output FIFO non-empty.
- out_pop[4]  in  1  downstream consumes the current head.
- drop_cnt  out  8  count of dropped packets; saturates at 255.

## Operation
Header fields:
- dst_r = data[PCKG_SZ-1:PCKG_SZ-4]
- dst_c = data[PCKG_SZ-5:PCKG_SZ-8]
- A packet is broadcast when data[PCKG_SZ-1:PCKG_SZ-8] == BDCST.

Routing (row-first, evaluated in this order):
- dst_r < ID_R: port 0.
- dst_r > ID_R: port 2.
- Rows equal and dst_c > ID_C: port 1.
- Rows equal and dst_c < ID_C: port 3.
- Both equal: drop.
- Broadcast: every output port except the source port.

Arbiter FSM, two states:
- IDLE:
  - Scan ports starting at rr, then rr+1 .. rr+3 (mod 4).
  - Pick the first port with in_pndng=1 whose target FIFO(s) all have count < FIFO_DEPTH.
  - A drop target always qualifies.
  - A broadcast qualifies only if all 3 targets have room.
  - On a hit: latch grant g, its data and the target mask; go to XFER.
  - On no hit: stay in IDLE.
- XFER:
  - in_pop[g]=1 for exactly this cycle.
  - At the closing edge, push the latched data into every target FIFO, or increment drop_cnt for a drop.
  - rr <= g+1 (mod 4); return to IDLE.

Output FIFOs:
- Circular buffer; pointer width $clog2(FIFO_DEPTH); count width $clog2(FIFO_DEPTH+1).
- out_pndng = (count != 0).
- out_data = mem[rd_ptr] when non-empty, 0 when empty.
- out_pop while empty is ignored; the pointer does not move.
- Simultaneous push and pop: count unchanged, both pointers advance, wrap at FIFO_DEPTH-1 -> 0.
- Full is checked in IDLE. A downstream pop can only free space before the push, so a push never overflows.

## Timing
- Throughput: at most 1 packet per 2 cycles per router.
- Latency, from edge k where in_pndng=1 is sampled and the port wins:
  - in_pop high during cycle k..k+1.
  - Data is in the output FIFO, out_pndng=1, after edge k+1.
- in_pop is decoded from registered state (no combinational path from inputs) and is never asserted in IDLE.
- Blocked or non-pending ports are skipped in the same IDLE cycle; no idle cycle is spent on them.
- Reset values: state=IDLE, rr=0, in_pop=0, all FIFOs empty, out_pndng=0, out_data=0, drop_cnt=0.
- Reset asserted during XFER: in_pop drops immediately, no push occurs, and the packet remains upstream.

## Test plan
With ID_R=2, ID_C=2, ROWS=COLUMNS=4, PCKG_SZ=40, FIFO_DEPTH=4:
- Unicast: in_pndng[1]=1, header 8'h12 sampled at edge 0 -> in_pop[1] high for 1 cycle after edge 0; out_pndng[0]=1 with out_data = the packet after edge 1; other outputs stay empty.
- Round-robin: all 4 inputs pending with headers 8'h12, 8'h32, 8'h23, 8'h21 from rr=0 -> in_pop pulses for ports 0,1,2,3 at cycles 1,3,5,7; each lands on its routed output.
- Backpressure: 4 packets queued to output 1, out_pop[1]=0:
  - A 5th packet to E on port 3 is never popped, while port 0 traffic to 8'h32 is still served.
  - After one out_pop[1] pulse, the port 3 packet is granted within 2 cycles.
- Broadcast: port 2 header 8'hFF -> one push lands in outputs 0, 1 and 3 on the same edge, output 2 stays empty. With output 3 pre-filled to 4 entries, the broadcast is not granted and in_pop[2] stays 0.
- Drop and saturation: header 8'h22 -> popped, no output push, drop_cnt 0->1. After 300 such packets, drop_cnt = 255.
- Reset mid-transfer: assert rst during XFER -> in_pop[g]=0 immediately; after release the same packet is re-granted and delivered exactly once.
